// File: rtl/vmst_way_feeder.sv
// Refill engine for the merge-sorter tree: round-robin picks a starving way, requests a block
// upstream, forwards the returned block one cycle later. Request holds until i_req_rdy; no backpressure toward the tree.
module vmst_way_feeder #(
    parameter int W_LOG   = 5,
    parameter int P_LOG   = 3,
    parameter int MAX_OUT = 4,
    parameter int DATW    = 64
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [(1<<W_LOG)-1:0]       i_emp,
    output logic [(DATW<<P_LOG)-1:0]    o_din,
    output logic                        o_dinen,
    output logic [W_LOG-1:0]            o_din_idx,
    output logic                        o_req,
    output logic [W_LOG-1:0]            o_req_idx,
    input  logic                        i_req_rdy,
    input  logic                        i_rsp_valid,
    input  logic [W_LOG-1:0]            i_rsp_idx,
    input  logic [(DATW<<P_LOG)-1:0]    i_rsp_data,
    input  logic                        i_rsp_last,
    output logic                        o_all_done,
    output logic                        o_err
);
    localparam int NW = 1 << W_LOG;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [NW-1:0]    pending, done, eligible, pend_nxt, done_nxt;
    logic [CW-1:0]    out_cnt, out_cnt_nxt;
    logic [CW:0]      inflight;
    logic [W_LOG-1:0] rr_ptr, gnt_idx, scan_idx;
    logic             gnt_vld, req_hs, rsp_ok, can_issue, req_nxt;

    always_comb begin
        req_hs    = o_req & i_req_rdy;
        // A response with nothing counted in flight would underflow the counter; treat it as a protocol error.
        rsp_ok    = i_rsp_valid & pending[i_rsp_idx] & ~done[i_rsp_idx] & ((out_cnt != '0) | req_hs);
        eligible  = i_emp & ~pending & ~done;
        // The request handshaking this cycle already counts against the in-flight limit.
        inflight  = {1'b0, out_cnt} + (CW+1)'(req_hs);
        can_issue = (~o_req | i_req_rdy) & (inflight < (CW+1)'(MAX_OUT));

        gnt_vld  = 1'b0;
        gnt_idx  = rr_ptr;
        scan_idx = rr_ptr;
        for (int i = 1; i <= NW; i++) begin
            scan_idx = rr_ptr + W_LOG'(i);
            if (can_issue && !gnt_vld && eligible[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end

        // Pending drops only after o_dinen has reached the tree, so emp is current before re-arbitration.
        pend_nxt = pending;
        if (o_dinen) pend_nxt[o_din_idx] = 1'b0;
        if (gnt_vld) pend_nxt[gnt_idx] = 1'b1;

        done_nxt = done;
        if (rsp_ok && i_rsp_last) done_nxt[i_rsp_idx] = 1'b1;

        out_cnt_nxt = out_cnt + CW'(req_hs) - CW'(rsp_ok);
        req_nxt     = gnt_vld | (o_req & ~req_hs);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_req      <= 1'b0;
            o_req_idx  <= '0;
            o_dinen    <= 1'b0;
            o_din      <= '0;
            o_din_idx  <= '0;
            o_all_done <= 1'b0;
            o_err      <= 1'b0;
            pending    <= '0;
            done       <= '0;
            out_cnt    <= '0;
            rr_ptr     <= '1;
        end else begin
            o_req <= req_nxt;
            if (gnt_vld) begin
                o_req_idx <= gnt_idx;
                rr_ptr    <= gnt_idx;
            end
            o_dinen <= rsp_ok;
            if (rsp_ok) begin
                o_din     <= i_rsp_data;
                o_din_idx <= i_rsp_idx;
            end
            pending    <= pend_nxt;
            done       <= done_nxt;
            out_cnt    <= out_cnt_nxt;
            o_err      <= o_err | (i_rsp_valid & ~rsp_ok);
            o_all_done <= o_all_done | (&done_nxt & (out_cnt_nxt == '0) & ~req_nxt);
        end
    end
endmodule
